// File: rtl/sbox_share_arb.sv
// Round-robin arbiter and two-stage pipeline sharing one 16-lane S-box between two requesters.
// Stage A drives the S-box inputs; stage B captures its output and presents the response.
module sbox_share_arb #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic          r0_mode,
    input  logic [127:0]  r0_data,
    input  logic [TW-1:0] r0_tag,
    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic          r1_mode,
    input  logic [127:0]  r1_data,
    input  logic [TW-1:0] r1_tag,
    output logic          sb_mode,
    output logic [127:0]  sb_rko,
    input  logic [127:0]  sb_sbo,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_id,
    output logic [TW-1:0] out_tag,
    output logic [127:0]  out_data,
    output logic [1:0]    inflight
);

    logic          a_valid;
    logic          a_id;
    logic          a_mode;
    logic [TW-1:0] a_tag;
    logic [127:0]  a_data;

    logic          b_valid;
    logic          b_id;
    logic [TW-1:0] b_tag;
    logic [127:0]  b_data;

    logic          last_grant;
    logic          grant_id;
    logic          a_to_b;
    logic          a_can_accept;
    logic          accept;

    assign a_to_b       = a_valid & (~b_valid | out_ready);
    assign a_can_accept = ~a_valid | a_to_b;

    // On contention the requester that did not win last time goes first.
    assign grant_id = (r0_valid & r1_valid) ? ~last_grant : r1_valid;

    assign r0_ready = a_can_accept & r0_valid & ~grant_id;
    assign r1_ready = a_can_accept & r1_valid & grant_id;
    assign accept   = r0_ready | r1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant_id;
        end
    end

    // Payload registers hold their last value when idle so the S-box inputs stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_id    <= 1'b0;
            a_mode  <= 1'b0;
            a_tag   <= '0;
            a_data  <= '0;
        end else if (accept) begin
            a_valid <= 1'b1;
            a_id    <= grant_id;
            a_mode  <= grant_id ? r1_mode : r0_mode;
            a_tag   <= grant_id ? r1_tag  : r0_tag;
            a_data  <= grant_id ? r1_data : r0_data;
        end else if (a_to_b) begin
            a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid <= 1'b0;
            b_id    <= 1'b0;
            b_tag   <= '0;
            b_data  <= '0;
        end else if (a_to_b) begin
            b_valid <= 1'b1;
            b_id    <= a_id;
            b_tag   <= a_tag;
            b_data  <= sb_sbo;
        end else if (b_valid & out_ready) begin
            b_valid <= 1'b0;
        end
    end

    assign sb_mode   = a_mode;
    assign sb_rko    = a_data;
    assign out_valid = b_valid;
    assign out_id    = b_id;
    assign out_tag   = b_tag;
    assign out_data  = b_data;
    assign inflight  = {1'b0, a_valid} + {1'b0, b_valid};

endmodule

// File: tb/tb_sbox_share_arb.sv
// Scoreboard bench for sbox_share_arb with a behavioural AES S-box on the shared datapath port.
// Drivers push hand-computed expectations at accept; a monitor pops them at each response.
module tb_sbox_share_arb;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          r0_valid = 1'b0, r1_valid = 1'b0;
    logic          r0_ready, r1_ready;
    logic          r0_mode = 1'b0, r1_mode = 1'b0;
    logic [127:0]  r0_data = '0, r1_data = '0;
    logic [3:0]    r0_tag = '0, r1_tag = '0;
    logic          sb_mode;
    logic [127:0]  sb_rko;
    logic [127:0]  sb_sbo;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_id;
    logic [3:0]    out_tag;
    logic [127:0]  out_data;
    logic [1:0]    inflight;

    sbox_share_arb #(.TW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_mode(r0_mode), .r0_data(r0_data), .r0_tag(r0_tag),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_mode(r1_mode), .r1_data(r1_data), .r1_tag(r1_tag),
        .sb_mode(sb_mode), .sb_rko(sb_rko), .sb_sbo(sb_sbo),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_tag(out_tag),
        .out_data(out_data), .inflight(inflight)
    );

    always #5 clk = ~clk;

    // AES S-box built from GF(2^8) inversion and the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        logic [7:0] p = a;
        logic [7:0] e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] fsb(input logic [7:0] a);
        logic [7:0] b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] isb(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    always_comb begin
        sb_sbo = '0;
        for (int i = 0; i < 16; i++)
            sb_sbo[8*i +: 8] = sb_mode ? isb(sb_rko[8*i +: 8]) : fsb(sb_rko[8*i +: 8]);
    end

    typedef struct {
        logic         id;
        logic [3:0]   tag;
        logic [127:0] data;
        int           acc;
    } exp_t;

    exp_t sb_q[$];
    int   grants[$];
    int   resp_cyc[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_lat = 0;
    int   resp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: sample mid-cycle so the handshake seen here is the one taken at the next edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            resp_cnt++;
            resp_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_response: got id %0d tag %h data %h, expected none", out_id, out_tag, out_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("resp_id", 128'(out_id), 128'(e.id));
                chk("resp_tag", 128'(out_tag), 128'(e.tag));
                chk("resp_data", out_data, e.data);
                last_lat = cyc - e.acc;
            end
        end
    end

    task automatic send(input int n, input logic mode, input logic [127:0] d,
                        input logic [3:0] tag, input logic [127:0] exp);
        bit   ok;
        int   k;
        exp_t e;
        ok = 1'b0;
        k  = 0;
        if (n == 0) begin
            r0_valid = 1'b1; r0_mode = mode; r0_data = d; r0_tag = tag;
        end else begin
            r1_valid = 1'b1; r1_mode = mode; r1_data = d; r1_tag = tag;
        end
        while (!ok && k < 60) begin
            @(negedge clk);
            k++;
            if ((n == 0) ? r0_ready : r1_ready) begin
                ok = 1'b1;
                e.id = n[0]; e.tag = tag; e.data = exp; e.acc = cyc;
                sb_q.push_back(e);
                grants.push_back(n);
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: requester %0d not accepted, expected accept within 60 cycles", n);
        end
        @(posedge clk);
        #1;
        if (n == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0 && inflight == 2'd0 && !r0_valid && !r1_valid) done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d responses still pending, expected 0", sb_q.size());
        end
    endtask

    task automatic clear_logs();
        grants.delete();
        resp_cyc.delete();
        resp_cnt = 0;
    endtask

    logic [127:0] z, s63, s7c, sed, s01, s53, dl, el;

    initial begin
        z   = '0;
        s01 = {16{8'h01}};
        s53 = {16{8'h53}};
        s63 = {16{8'h63}};
        s7c = {16{8'h7c}};
        sed = {16{8'hed}};

        #12;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_id", 128'(out_id), 128'd0);
        chk("rst_out_tag", 128'(out_tag), 128'd0);
        chk("rst_out_data", out_data, z);
        chk("rst_sb_rko", sb_rko, z);
        chk("rst_sb_mode", 128'(sb_mode), 128'd0);
        chk("rst_inflight", 128'(inflight), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Contention: both requesters busy, grants alternate starting with r0.
        clear_logs();
        fork
            begin
                send(0, 1'b0, z,   4'h0, s63);
                send(0, 1'b0, s01, 4'h1, s7c);
                send(0, 1'b0, s53, 4'h2, sed);
            end
            begin
                send(1, 1'b1, s63, 4'h8, z);
                send(1, 1'b1, s7c, 4'h9, s01);
                send(1, 1'b1, sed, 4'ha, s53);
            end
        join
        drain();
        chk("cont_accepts", 128'(grants.size()), 128'd6);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            chk("cont_grant", 128'(grants[i]), 128'(i % 2));
        chk("cont_resp_cnt", 128'(resp_cyc.size()), 128'd6);
        for (int i = 0; i + 1 < resp_cyc.size(); i++)
            chk("cont_resp_gap", 128'(resp_cyc[i+1] - resp_cyc[i]), 128'd1);

        // Single forward request and its latency.
        clear_logs();
        send(0, 1'b0, z, 4'h5, s63);
        drain();
        chk("fwd_resp_cnt", 128'(resp_cnt), 128'd1);
        chk("fwd_latency", 128'(last_lat), 128'd2);

        // Inverse request, then a forward request with a distinct lane.
        send(1, 1'b1, s63, 4'h3, z);
        dl = '0; dl[47:40] = 8'h53; dl[7:0] = 8'h01;
        el = s63; el[47:40] = 8'hed; el[7:0] = 8'h7c;
        send(1, 1'b0, dl, 4'h4, el);
        drain();

        // Backpressure: two fill the pipe, the third stalls until release.
        clear_logs();
        out_ready = 1'b0;
        send(0, 1'b0, z,   4'h1, s63);
        send(1, 1'b1, s63, 4'h2, z);
        fork
            send(0, 1'b0, s01, 4'h3, s7c);
        join_none
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("bp_inflight", 128'(inflight), 128'd2);
            chk("bp_ready", 128'({r0_ready, r1_ready}), 128'd0);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_out_data", out_data, s63);
            chk("bp_out_tag", 128'(out_tag), 128'h1);
        end
        out_ready = 1'b1;
        drain();
        chk("bp_resp_cnt", 128'(resp_cnt), 128'd3);
        chk("bp_accept_order", 128'({grants.size() == 3 ? grants[2] : 9}), 128'd0);

        // Mixed modes back-to-back.
        clear_logs();
        send(0, 1'b0, z,   4'h6, s63);
        send(1, 1'b1, s63, 4'h7, z);
        drain();
        chk("mix_resp_cnt", 128'(resp_cyc.size()), 128'd2);
        if (resp_cyc.size() == 2)
            chk("mix_resp_gap", 128'(resp_cyc[1] - resp_cyc[0]), 128'd1);

        // Reset with two in flight; last accept is r0 so a kept grant history would favour r1.
        clear_logs();
        out_ready = 1'b0;
        send(1, 1'b1, s63, 4'hb, z);
        send(0, 1'b0, z,   4'hc, s63);
        chk("prerst_inflight", 128'(inflight), 128'd2);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_inflight", 128'(inflight), 128'd0);
        chk("midrst_out_data", out_data, z);
        chk("midrst_sb_rko", sb_rko, z);
        sb_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        clear_logs();
        fork
            send(0, 1'b0, s53, 4'hd, sed);
            send(1, 1'b1, s7c, 4'he, s01);
        join
        drain();
        chk("postrst_first_grant", 128'(grants.size() > 0 ? grants[0] : 9), 128'd0);
        chk("postrst_resp_cnt", 128'(resp_cnt), 128'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000, expected finish");
        $fatal(1, "timeout");
    end

endmodule
